// File: rtl/pc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_ctrl
// Description : Program-counter sequencer for the fetch stage. It handles the
//               boot cycle, sequential fetch, hazard hold and prioritised
//               trap/branch/jump redirects, including redirects that arrive
//               while a fetch request is still waiting to be accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_seq_ctrl #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              trap_req_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              br_req_i,
    input  logic [ADDR_W-1:0] br_addr_i,
    input  logic              jmp_req_i,
    input  logic [ADDR_W-1:0] jmp_addr_i,
    input  logic              stall_i,
    input  logic              if_ready_i,
    output logic              if_req_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              flush_o,
    output logic [1:0]        state_o
);

    localparam logic [1:0] C_BOOT = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_HOLD = 2'd2;
    localparam logic [1:0] C_PEND = 2'd3;

    localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(4);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pend_addr;
    logic              r_pend_trap;

    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pend_addr_nxt;
    logic              w_pend_trap_nxt;
    logic              w_if_req;
    logic              w_handshake;
    logic              w_redir;
    logic              w_flush;
    logic [ADDR_W-1:0] w_target_raw;
    logic [ADDR_W-1:0] w_target;

    // A request is withdrawn during a stall cycle so no fetch can complete
    // while the pc is frozen; in PEND the request must stay up until taken.
    assign w_if_req    = ((r_state == C_RUN) && !stall_i) || (r_state == C_PEND);
    assign w_handshake = w_if_req && if_ready_i;

    always_comb begin
        w_target_raw = jmp_addr_i;
        if (trap_req_i) begin
            w_target_raw = trap_addr_i;
        end else if (br_req_i) begin
            w_target_raw = br_addr_i;
        end
    end

    assign w_target = {w_target_raw[ADDR_W-1:2], 2'b00};

    // A pending trap target may only be replaced by another trap.
    assign w_redir = (r_state != C_BOOT)
                   && (trap_req_i || br_req_i || jmp_req_i)
                   && !((r_state == C_PEND) && r_pend_trap && !trap_req_i);

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_pend_addr_nxt = r_pend_addr;
        w_pend_trap_nxt = r_pend_trap;
        w_flush         = 1'b0;

        if (r_state == C_BOOT) begin
            w_state_nxt = C_RUN;
            w_pc_nxt    = RESET_ADDR;
        end else if (w_redir) begin
            w_flush = 1'b1;
            if (!w_if_req || if_ready_i) begin
                w_pc_nxt        = w_target;
                w_state_nxt     = C_RUN;
                w_pend_addr_nxt = '0;
                w_pend_trap_nxt = 1'b0;
            end else begin
                w_pend_addr_nxt = w_target;
                w_pend_trap_nxt = trap_req_i;
                w_state_nxt     = C_PEND;
            end
        end else begin
            case (r_state)
                C_RUN: begin
                    if (stall_i) begin
                        w_state_nxt = C_HOLD;
                    end else if (w_handshake) begin
                        w_pc_nxt = r_pc + C_PC_STEP;
                    end
                end
                C_HOLD: begin
                    if (!stall_i) begin
                        w_state_nxt = C_RUN;
                    end
                end
                C_PEND: begin
                    if (w_handshake) begin
                        w_pc_nxt        = r_pend_addr;
                        w_state_nxt     = C_RUN;
                        w_pend_addr_nxt = '0;
                        w_pend_trap_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = C_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= C_BOOT;
            r_pc        <= RESET_ADDR;
            r_pend_addr <= '0;
            r_pend_trap <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_pend_addr <= w_pend_addr_nxt;
            r_pend_trap <= w_pend_trap_nxt;
        end
    end

    assign if_req_o = w_if_req;
    assign pc_o     = r_pc;
    assign flush_o  = w_flush;
    assign state_o  = r_state;

endmodule
`default_nettype wire
